// File: rtl/rv_pipe_pkg.sv
// Shared types and stage indices for the RV pipeline controller.
package rv_pipe_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_state_e;

    localparam int PC_S   = 0;
    localparam int IFID_S = 1;
    localparam int IDEX_S = 2;

    // Wide enough for the largest legal MEM_TIMEOUT (255).
    localparam int WAIT_W = 8;

endpackage

// File: rtl/rv_sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear wins over increment.
module rv_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: registered state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/rv_pipe_ctrl.sv
// Per-stage stall/flush controller: memory wait with timeout, EX redirect,
// load-use bubbling and a saturating stall-cycle counter.
module rv_pipe_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int NSTAGE      = 4,
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_sync,
    input  logic              jump_en_ex,
    input  logic [XLEN-1:0]   jump_addr_ex,
    input  logic              load_ex,
    input  logic [4:0]        rd_ex,
    input  logic [4:0]        rs1_id,
    input  logic [4:0]        rs2_id,
    input  logic              rs1_used_id,
    input  logic              rs2_used_id,
    input  logic              mem_req,
    input  logic              mem_ack,
    output logic              jump,
    output logic [XLEN-1:0]   jump_addr,
    output logic [NSTAGE-1:0] stall_n,
    output logic [NSTAGE-1:0] flush,
    output logic              mem_timeout,
    output logic [CNT_W-1:0]  stall_cnt
);

    pipe_state_e       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [XLEN-1:0]   jump_addr_q;
    logic              load_use;
    logic              mem_stall;
    logic              timeout_hit;

    // x0 is hardwired zero, so a load targeting it never creates a dependency.
    assign load_use = load_ex && (rd_ex != 5'd0) &&
                      ((rs1_used_id && (rs1_id == rd_ex)) ||
                       (rs2_used_id && (rs2_id == rd_ex)));

    // Dropping mem_req while waiting counts as completion, not as a stall.
    assign mem_stall   = mem_req && !mem_ack;
    assign timeout_hit = (state_q == MEM_WAIT) && mem_stall &&
                         (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = RUN;
        wait_cnt_d  = '0;
        stall_n     = '1;
        flush       = '0;
        jump        = 1'b0;
        mem_timeout = 1'b0;
        if (!rst_sync) begin
            if (timeout_hit) begin
                // Abandon the access and clear everything behind the PC, including any EX jump.
                mem_timeout  = 1'b1;
                flush        = '1;
                flush[PC_S]  = 1'b0;
            end else if (mem_stall) begin
                stall_n    = '0;
                state_d    = MEM_WAIT;
                wait_cnt_d = (state_q == RUN) ? WAIT_W'(1) : wait_cnt_q + WAIT_W'(1);
            end else if (jump_en_ex) begin
                jump           = 1'b1;
                flush[IFID_S]  = 1'b1;
                flush[IDEX_S]  = 1'b1;
            end else if (load_use) begin
                stall_n[PC_S]   = 1'b0;
                stall_n[IFID_S] = 1'b0;
                flush[IDEX_S]   = 1'b1;
            end
        end
    end

    assign jump_addr = jump ? jump_addr_ex : jump_addr_q;

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            jump_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (jump) begin
                jump_addr_q <= jump_addr_ex;
            end
        end
    end

    rv_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr   (rst_sync),
        .inc   (~&stall_n),
        .count (stall_cnt)
    );

endmodule

// File: doc/rv_pipe_ctrl.md
# rv_pipe_ctrl

Parametrised pipeline controller for the RV core; successor to the single-stall/single-flush core controller. It owns per-stage stall and flush for an N-stage pipeline (PC, IF/ID, ID/EX, then NSTAGE-3 post-EX registers). It adds load-use hazard bubbling, multi-cycle data-memory wait with timeout recovery, and a saturating stall-cycle counter. It sits beside the PC register and pipeline registers in the core top and drives their stall_n/flush inputs.

## Interface
- NSTAGE, 4: number of pipeline registers incl. PC (index 0 PC, 1 IF/ID, 2 ID/EX, 3..NSTAGE-1 post-EX); legal ≥4
- XLEN, 32: address width
- MEM_TIMEOUT, 16: max wait cycles for mem_ack; legal 2..255
- CNT_W, 32: stall counter width

One clock; reset is synchronous and active-high.
- clk  in  1  core clock
- rst_sync  in  1  synchronous active-high reset
- jump_en_ex  in  1  EX stage requests redirect
- jump_addr_ex  in  XLEN  redirect target
- load_ex  in  1  instr in EX is a load writing rd_ex
- rd_ex  in  5  destination of EX instr
- rs1_id, rs2_id  in  5 each  ID source registers
- rs1_used_id, rs2_used_id  in  1 each  ID actually reads that source
- mem_req  in  1  stage NSTAGE-1 instr accesses data memory
- mem_ack  in  1  memory completes this cycle
- jump  out  1  PC redirect strobe
- jump_addr  out  XLEN  PC redirect target
- stall_n  out  NSTAGE  per-register hold (0 = hold)
- flush  out  NSTAGE  per-register clear to bubble (flush[0] always 0)
- mem_timeout  out  1  one-cycle error pulse
- stall_cnt  out  CNT_W  cycles with any stall_n bit low, saturating

## Operation
- FSM states RUN, MEM_WAIT (enum in package). Reset: RUN, wait_cnt=0, stall_cnt=0.
- Reset outputs: stall_n all 1, flush all 0, jump 0, jump_addr 0, mem_timeout 0.
- Priority each cycle: memory stall > jump > load-use.
- Memory stall: mem_req && !mem_ack → all stall_n=0, flush 0, jump 0. In RUN, go to MEM_WAIT with wait_cnt=1. In MEM_WAIT, wait_cnt increments.
- mem_ack in MEM_WAIT (or with mem_req in RUN): all stall_n=1 that cycle → RUN, wait_cnt=0.
- Timeout: in MEM_WAIT with wait_cnt==MEM_TIMEOUT-1 and no ack:
  - mem_timeout=1, stall_n all 1, flush[1..NSTAGE-1]=1, jump=0 (EX jump discarded with the flush).
  - Next state RUN.
- Jump (RUN, no memory stall): jump=1, jump_addr=jump_addr_ex, flush[1]=flush[2]=1, stall_n all 1.
- Load-use (RUN, no memory stall, no jump):
  - Condition: load_ex && rd_ex!=0 && ((rs1_used_id && rs1_id==rd_ex) || (rs2_used_id && rs2_id==rd_ex)).
  - Response: stall_n[0]=stall_n[1]=0, flush[2]=1, others advance.
- jump_addr holds its last driven value when jump=0.
- stall_cnt increments when any stall_n bit is 0 and saturates at all-ones.
- rd_ex==0 never causes a hazard.

## Timing
- All outputs are combinational from inputs and state; FSM, wait_cnt and stall_cnt are registered.
- Latency: zero-cycle redirect. Load-use costs exactly one bubble cycle. Memory wait costs n stall cycles for ack arriving n cycles after first req.
- Jump held by a memory stall is issued in the ack cycle (EX is frozen, so jump_en_ex remains asserted).
- rst_sync asserted in MEM_WAIT: next cycle is RUN, counters 0, outputs at reset values; reset dominates all inputs.
- mem_req dropping in MEM_WAIT without ack is treated as ack: release, RUN.

## Structure
- Package rv_pipe_pkg:
  - state enum {RUN, MEM_WAIT}
  - stage index localparams PC_S=0, IFID_S=1, IDEX_S=2
- Sub-module rv_sat_counter (parametrised width, inc, sync clear) for stall_cnt.
- FSM, hazard compare and output mux stay in rv_pipe_ctrl.

## Test plan
- Reset mid-wait: rst_sync during MEM_WAIT → next cycle stall_n=4'b1111, flush=0, stall_cnt=0, state RUN.
- Load-use: load_ex=1, rd_ex=5, rs2_id=5, rs2_used_id=1 → one cycle stall_n=4'b1100, flush=4'b0100; rd_ex=0 case → no stall.
- Jump: jump_en_ex=1, jump_addr_ex=0x80 with concurrent load-use → jump=1, jump_addr=0x80, flush=4'b0110, stall_n=4'b1111.
- Memory wait with jump: mem_req=1, ack after 3 cycles while jump_en_ex=1 →
  - 3 cycles stall_n=0, jump=0;
  - ack cycle: jump=1;
  - stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, mem_req held, no ack → stall 3 cycles, then mem_timeout pulse, flush=4'b1110, RUN.
- Saturation: CNT_W=4, 20 stalled cycles → stall_cnt=15.
